// File: rtl/ucsbece154b_perf_pkg.sv
// Shared constants for the dual-issue performance monitor: counter indices,
// RV32 opcodes of interest, FSM encoding and the issued-instruction helper.
package ucsbece154b_perf_pkg;

  localparam int NUM_CNT  = 7;
  localparam int NUM_SLOT = 8;

  localparam logic [2:0] CYCLES   = 3'd0;
  localparam logic [2:0] INSTR    = 3'd1;
  localparam logic [2:0] BRANCH   = 3'd2;
  localparam logic [2:0] BR_MISS  = 3'd3;
  localparam logic [2:0] JUMP     = 3'd4;
  localparam logic [2:0] JMP_MISS = 3'd5;
  localparam logic [2:0] STALLS   = 3'd6;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  function automatic logic is_real_instr(input logic [31:0] instr, input logic [31:0] nop);
    return (instr != 32'd0) && (instr != nop);
  endfunction

  function automatic logic [1:0] count_issued(input logic [31:0] d1, input logic [31:0] d2,
                                              input logic [31:0] nop);
    return {1'b0, is_real_instr(d1, nop)} + {1'b0, is_real_instr(d2, nop)};
  endfunction

endpackage

// File: rtl/ucsbece154b_perf_monitor_if.sv
// Event strobes from the pipeline plus the software read port of the monitor.
// CNT_W must match the CNT_W of the monitor the interface is bound to.
interface ucsbece154b_perf_monitor_if #(
  parameter int CNT_W = 32
) ();

  logic             clear_i;
  logic [31:0]      PCF_i;
  logic [31:0]      PCF2_i;
  logic [31:0]      InstrF_i;
  logic [31:0]      InstrF2_i;
  logic [31:0]      InstrD_i;
  logic [31:0]      InstrD2_i;
  logic [6:0]       opE_i;
  logic             MispredictE_i;
  logic             BranchTakenF_i;
  logic             Hazard_i;
  logic             rd_en_i;
  logic [2:0]       rd_addr_i;
  logic [CNT_W-1:0] rdata_o;
  logic             rvalid_o;
  logic             halted_o;

  modport master (
    output clear_i, PCF_i, PCF2_i, InstrF_i, InstrF2_i, InstrD_i, InstrD2_i, opE_i,
           MispredictE_i, BranchTakenF_i, Hazard_i, rd_en_i, rd_addr_i,
    input  rdata_o, rvalid_o, halted_o
  );

  modport slave (
    input  clear_i, PCF_i, PCF2_i, InstrF_i, InstrF2_i, InstrD_i, InstrD2_i, opE_i,
           MispredictE_i, BranchTakenF_i, Hazard_i, rd_en_i, rd_addr_i,
    output rdata_o, rvalid_o, halted_o
  );

endinterface

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating event counter adding 0..2 per enabled cycle; clr wins over en.
module ucsbece154b_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W:0]   sum_s;

  // Widened sum so a carry out flags saturation instead of wrapping.
  always_comb begin
    sum_s = {1'b0, count_r} + {{(W-1){1'b0}}, inc};
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      if (sum_s[W]) begin
        count_r <= '1;
      end else begin
        count_r <= sum_s[W-1:0];
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// Dual-issue pipeline performance monitor with halt detection and a read port.
// Optional STALLS counter at address 6 is built when PERF_HAZARD_EN is defined.
module ucsbece154b_perf_monitor
  import ucsbece154b_perf_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          HALT_HOLD = 2
) (
  input logic                        clk,
  input logic                        reset,
  ucsbece154b_perf_monitor_if.slave  bus
);

  localparam int PARK_W = (HALT_HOLD < 2) ? 1 : $clog2(HALT_HOLD + 1);
  localparam logic [PARK_W-1:0] PARK_MAX = PARK_W'(HALT_HOLD);

  state_t              state_r;
  logic [PARK_W-1:0]   park_cnt_r;
  logic [PARK_W-1:0]   park_next_s;
  logic [31:0]         prev_pc1_r;
  logic [31:0]         prev_pc2_r;
  logic                halted_r;
  logic [CNT_W-1:0]    rdata_r;
  logic                rvalid_r;
  logic                parked_s;
  logic                run_s;
  logic [1:0]          inc_s [0:5];
  logic [CNT_W-1:0]    cnt_s [0:NUM_SLOT-1];

  assign run_s = (state_r == RUN);

  // Per-cycle event decode into increment amounts for each counter.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      inc_s[i] = 2'd0;
    end
    inc_s[CYCLES] = 2'd1;
    inc_s[INSTR]  = count_issued(bus.InstrD_i, bus.InstrD2_i, NOP_INSTR);
    case (bus.opE_i)
      OP_BRANCH: begin
        inc_s[BRANCH]  = 2'd1;
        inc_s[BR_MISS] = {1'b0, bus.MispredictE_i};
      end
      OP_JAL, OP_JALR: begin
        inc_s[JUMP]     = 2'd1;
        inc_s[JMP_MISS] = {1'b0, !bus.BranchTakenF_i};
      end
      default: begin
        inc_s[BRANCH] = 2'd0;
      end
    endcase
  end

  // Both fetch slots sitting on a NOP at an unchanged PC counts as parked.
  always_comb begin
    parked_s = (bus.PCF_i == prev_pc1_r) && (bus.InstrF_i == NOP_INSTR) &&
               (bus.PCF2_i == prev_pc2_r) && (bus.InstrF2_i == NOP_INSTR);
    if (!parked_s) begin
      park_next_s = '0;
    end else if (park_cnt_r == PARK_MAX) begin
      park_next_s = park_cnt_r;
    end else begin
      park_next_s = park_cnt_r + {{(PARK_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_cnt
    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clear_i),
      .en    (run_s),
      .inc   (inc_s[g]),
      .count (cnt_s[g])
    );
  end

`ifdef PERF_HAZARD_EN
  ucsbece154b_sat_counter #(.W(CNT_W)) u_stalls (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear_i),
    .en    (run_s),
    .inc   ({1'b0, bus.Hazard_i}),
    .count (cnt_s[STALLS])
  );
`else
  logic hazard_unused_s;
  assign hazard_unused_s = bus.Hazard_i;
  assign cnt_s[STALLS]   = '0;
`endif

  assign cnt_s[7] = '0;

  // Control FSM, park tracking and registered read port; clear_i overrides halting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      park_cnt_r <= '0;
      prev_pc1_r <= 32'd0;
      prev_pc2_r <= 32'd0;
      halted_r   <= 1'b0;
      rdata_r    <= '0;
      rvalid_r   <= 1'b0;
    end else begin
      prev_pc1_r <= bus.PCF_i;
      prev_pc2_r <= bus.PCF2_i;
      rvalid_r   <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        rdata_r <= cnt_s[bus.rd_addr_i];
      end else begin
        rdata_r <= rdata_r;
      end
      if (bus.clear_i) begin
        state_r    <= RUN;
        park_cnt_r <= '0;
        halted_r   <= 1'b0;
      end else begin
        park_cnt_r <= park_next_s;
        halted_r   <= (state_r == HALTED);
        case (state_r)
          IDLE:    state_r <= RUN;
          RUN:     state_r <= (park_next_s == PARK_MAX) ? HALTED : RUN;
          HALTED:  state_r <= HALTED;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign bus.rdata_o  = rdata_r;
  assign bus.rvalid_o = rvalid_r;
  assign bus.halted_o = halted_r;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Scoreboard bench: a 32-bit and a 4-bit monitor see identical stimulus and are
// checked against one unbounded event-count model saturated per width at compare time.
module tb_ucsbece154b_perf_monitor;
  import ucsbece154b_perf_pkg::*;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int          HOLD = 2;
`ifdef PERF_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  typedef struct {
    logic [2:0]      addr;
    longint unsigned val;
  } rd_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, mis, btf, haz, rd_en;
  logic [31:0] pc1, pc2, if1, if2, id1, id2;
  logic [6:0]  ope;
  logic [2:0]  rd_addr;

  ucsbece154b_perf_monitor_if #(.CNT_W(32)) bus32 ();
  ucsbece154b_perf_monitor_if #(.CNT_W(4))  bus4 ();

  assign bus32.clear_i = clear;        assign bus4.clear_i = clear;
  assign bus32.PCF_i = pc1;            assign bus4.PCF_i = pc1;
  assign bus32.PCF2_i = pc2;           assign bus4.PCF2_i = pc2;
  assign bus32.InstrF_i = if1;         assign bus4.InstrF_i = if1;
  assign bus32.InstrF2_i = if2;        assign bus4.InstrF2_i = if2;
  assign bus32.InstrD_i = id1;         assign bus4.InstrD_i = id1;
  assign bus32.InstrD2_i = id2;        assign bus4.InstrD2_i = id2;
  assign bus32.opE_i = ope;            assign bus4.opE_i = ope;
  assign bus32.MispredictE_i = mis;    assign bus4.MispredictE_i = mis;
  assign bus32.BranchTakenF_i = btf;   assign bus4.BranchTakenF_i = btf;
  assign bus32.Hazard_i = haz;         assign bus4.Hazard_i = haz;
  assign bus32.rd_en_i = rd_en;        assign bus4.rd_en_i = rd_en;
  assign bus32.rd_addr_i = rd_addr;    assign bus4.rd_addr_i = rd_addr;

  ucsbece154b_perf_monitor #(.CNT_W(32), .NOP_INSTR(NOP), .HALT_HOLD(HOLD)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32));
  ucsbece154b_perf_monitor #(.CNT_W(4), .NOP_INSTR(NOP), .HALT_HOLD(HOLD)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  // Reference model state
  longint unsigned cnt_m [0:6];
  int              park_m;
  bit              started_m, halted_m;
  logic [31:0]     prev1_m, prev2_m;
  logic            exp_rvalid = 1'b0, exp_halted = 1'b0;
  rd_exp_t         exp_q [$];
  int              n_cmp = 0, n_bad = 0;

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int real_instr(input logic [31:0] v);
    return (v != 32'd0 && v != NOP) ? 1 : 0;
  endfunction

  function automatic longint unsigned read_val(input logic [2:0] a);
    if (a == 3'd7 || (a == 3'd6 && !HAZ)) return 64'd0;
    return cnt_m[a];
  endfunction

  task automatic model_edge();
    bit parked;
    rd_exp_t e;
    if (!reset) begin
      for (int i = 0; i < 7; i++) cnt_m[i] = 64'd0;
      park_m = 0; started_m = 1'b0; halted_m = 1'b0;
      prev1_m = 32'd0; prev2_m = 32'd0;
      exp_halted = 1'b0; exp_rvalid = 1'b0;
    end else begin
      exp_rvalid = rd_en;
      if (rd_en) begin
        e.addr = rd_addr; e.val = read_val(rd_addr);
        exp_q.push_back(e);
      end
      parked = (pc1 == prev1_m) && (if1 == NOP) && (pc2 == prev2_m) && (if2 == NOP);
      if (clear) begin
        for (int i = 0; i < 7; i++) cnt_m[i] = 64'd0;
        park_m = 0; started_m = 1'b1; halted_m = 1'b0; exp_halted = 1'b0;
      end else begin
        exp_halted = halted_m;
        if (started_m && !halted_m) begin
          cnt_m[0] += 1;
          cnt_m[1] += longint'(real_instr(id1) + real_instr(id2));
          if (ope == OP_BRANCH) begin
            cnt_m[2] += 1;
            if (mis) cnt_m[3] += 1;
          end else if (ope == OP_JAL || ope == OP_JALR) begin
            cnt_m[4] += 1;
            if (!btf) cnt_m[5] += 1;
          end
          if (HAZ && haz) cnt_m[6] += 1;
        end
        park_m = parked ? park_m + 1 : 0;
        if (!started_m) started_m = 1'b1;
        else if (!halted_m && park_m >= HOLD) halted_m = 1'b1;
      end
      prev1_m = pc1; prev2_m = pc2;
    end
  endtask

  // Monitor: compares DUT outputs half a cycle after each edge.
  always @(negedge clk) begin
    rd_exp_t e;
    n_cmp++;
    if (bus32.rvalid_o !== exp_rvalid || bus4.rvalid_o !== exp_rvalid) begin
      n_bad++;
      $display("FAIL rvalid: got %b/%b expected %b at %0t", bus32.rvalid_o, bus4.rvalid_o, exp_rvalid, $time);
    end
    n_cmp++;
    if (bus32.halted_o !== exp_halted || bus4.halted_o !== exp_halted) begin
      n_bad++;
      $display("FAIL halted: got %b/%b expected %b at %0t", bus32.halted_o, bus4.halted_o, exp_halted, $time);
    end
    if (exp_rvalid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: no expected read at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (64'(bus32.rdata_o) !== sat(e.val, 32) || 64'(bus4.rdata_o) !== sat(e.val, 4)) begin
          n_bad++;
          $display("FAIL rdata[%0d]: got %0d/%0d expected %0d/%0d at %0t", e.addr,
                   bus32.rdata_o, bus4.rdata_o, sat(e.val, 32), sat(e.val, 4), $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; rd_en = 1'b0; rd_addr = 3'd0; ope = 7'd0;
    mis = 1'b0; btf = 1'b1; haz = 1'b0;
    id1 = NOP; id2 = NOP; if1 = 32'd0; if2 = 32'd0;
  endtask

  task automatic adv_pc();
    pc1 = pc1 + 32'd8; pc2 = pc1 + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    do v = $urandom; while (v == 32'd0 || v == NOP);
    return v;
  endfunction

  task automatic rand_read();
    rd_en = 1'($urandom_range(0, 1)); rd_addr = 3'($urandom_range(0, 7));
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 3'(a);
      tick();
    end
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] pick_instr();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return NOP;
      default: return rand_instr();
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 3))
      0: return OP_BRANCH;
      1: return OP_JAL;
      2: return OP_JALR;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    idle(); reset = 1'b0; pc1 = 32'h100; pc2 = 32'h104;
    repeat (2) tick();
    reset = 1'b1;

    // dual issue, then slot1=0 / slot2=NOP
    for (int i = 0; i < 10; i++) begin
      id1 = rand_instr(); id2 = rand_instr(); adv_pc(); rand_read(); tick();
    end
    for (int i = 0; i < 5; i++) begin
      id1 = 32'd0; id2 = NOP; adv_pc(); rand_read(); tick();
    end
    idle(); read_all();

    // 4 branches (1 mispredict) and 3 jumps (one not predicted taken)
    for (int i = 0; i < 7; i++) begin
      ope = (i < 4) ? OP_BRANCH : ((i == 4) ? OP_JAL : OP_JALR);
      mis = (i == 1); btf = (i != 5); adv_pc(); tick();
    end
    idle(); read_all();

    // randomized traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      id1 = pick_instr(); id2 = pick_instr(); ope = pick_op();
      mis = 1'($urandom); btf = 1'($urandom); haz = 1'($urandom);
      if1 = $urandom; if2 = $urandom; adv_pc(); rand_read();
      clear = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();

    // mid-run reset with reads in flight
    reset = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_addr = 3'(i); id1 = rand_instr(); ope = OP_BRANCH; tick();
    end
    reset = 1'b1; idle(); adv_pc(); tick();
    read_all();

    // park both slots on NOP at 0x40/0x44 and keep issuing events
    pc1 = 32'h40; pc2 = 32'h44;
    for (int i = 0; i < 8; i++) begin
      if1 = NOP; if2 = NOP; id1 = rand_instr(); id2 = rand_instr();
      ope = pick_op(); haz = 1'b1; rand_read(); tick();
    end
    idle(); pc1 = 32'h40; pc2 = 32'h44; if1 = NOP; if2 = NOP;
    read_all();

    // clear with a same-cycle event
    clear = 1'b1; id1 = rand_instr(); id2 = rand_instr(); ope = OP_JAL; btf = 1'b0; haz = 1'b1;
    rd_en = 1'b1; rd_addr = CYCLES; tick();
    idle(); adv_pc(); read_all();

    // drive the 4-bit INSTR counter to 14, then issue 2
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      id1 = rand_instr(); id2 = rand_instr(); adv_pc(); tick();
    end
    id1 = NOP; id2 = NOP; rd_en = 1'b1; rd_addr = INSTR; adv_pc(); tick();
    id1 = rand_instr(); id2 = rand_instr(); rd_en = 1'b0; adv_pc(); tick();
    idle(); rd_en = 1'b1; rd_addr = INSTR; adv_pc(); tick();

    // 5 hazard cycles after a clear
    idle(); clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      haz = 1'b1; adv_pc(); tick();
    end
    idle(); read_all();
    repeat (2) tick();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
